capture_controller: RTL and testbench
=====================================

Name: capture_controller

Overview:
- Sits directly downstream of the 4-stage trigger; consumes its `run` output plus the sampled data stream.
- Writes samples into an external ring-buffer sample memory from `arm` onward.
- On `run`, captures a programmed number of post-trigger samples, then reads back a programmed number of samples newest-first.
- Hands each read sample to the serial transmitter over a send/busy handshake.

Parameters:
- ADDR_WIDTH, 13, sample memory address width (ring depth 2^ADDR_WIDTH words).
- DATA_WIDTH, 32, sample width; matches the trigger channel count.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- dataInput  in  32  sample word, valid when inputReady=1
- inputReady  in  1  one-cycle sample strobe from the sampler
- run  in  1  trigger fired (level from trigger block)
- arm  in  1  one-cycle command: start a new capture
- wrSize  in  1  one-cycle command: load size register from data
- data  in  32  command argument; [15:0]=readCount, [31:16]=delayCount
- busy  in  1  transmitter busy
- send  out  1  one-cycle pulse: txData valid, transmit it
- txData  out  32  sample word to transmitter
- memAddr  out  ADDR_WIDTH  registered memory address
- memWData  out  32  registered write data
- memWrite  out  1  one-cycle write strobe
- memRead  out  1  one-cycle read strobe; memRData valid next cycle
- memRData  in  32  memory read data (1-cycle latency)
- capturing  out  1  high in SAMPLE and DELAY states

Behaviour:
- Reset (reset=0, async): state IDLE.
  - Every output is 0: send, txData, memAddr, memWData, memWrite, memRead, capturing.
  - wrPtr, rdPtr, counter, readCount and delayCount are all 0.
- wrSize=1 (any state): readCount<=data[15:0], delayCount<=data[31:16]. The registers are read live; software loads them only in IDLE.
- States: IDLE, SAMPLE, DELAY, READ, READWAIT, SENDHOLD, SENDWAIT.
- arm=1 in any state:
  - Go to SAMPLE, counter<=0, send<=0.
  - arm has priority over run, over inputReady and over an in-progress readback (abort).
  - wrPtr is not cleared.
- SAMPLE: on inputReady, write dataInput at wrPtr (memWrite=1 next cycle), wrPtr<=wrPtr+1 modulo 2^ADDR_WIDTH.
  - run=1 -> DELAY, counter<=0.
  - A sample strobed in the same cycle as run is written and does not count toward the delay.
- DELAY: on inputReady, write as in SAMPLE and counter<=counter+1.
  - When counter=={delayCount,2'b11} and inputReady=1, write that sample, then go to READ, counter<=0, rdPtr<=wrPtr (post-increment value).
  - Post-trigger samples written = 4*(delayCount+1).
- run is ignored outside SAMPLE. inputReady is ignored outside SAMPLE/DELAY.
- READ:
  - If busy=0: memRead=1, memAddr<=rdPtr-1, rdPtr<=rdPtr-1 (wraps), go to READWAIT.
  - If busy=1: stay in READ.
- READWAIT: txData<=memRData, send<=1 for exactly one cycle, go to SENDHOLD.
- SENDHOLD: one cycle during which busy is ignored (transmitter latency), then SENDWAIT.
- SENDWAIT: wait for busy=0.
  - If counter=={readCount,2'b11}, go to IDLE.
  - Otherwise counter<=counter+1 and go to READ.
  - Samples sent = 4*(readCount+1), newest first.
- Readback counts above 2^ADDR_WIDTH wrap and resend older ring contents; no error flag.
- memWrite/memRead are never high in the same cycle. memAddr holds its last value when no strobe is active.
- Counter width is 18 bits (16-bit count plus 2 LSBs); compare is exact equality.

Decomposition:
- Shared package holds:
  - state encodings (3-bit localparams);
  - the command field offsets READCOUNT_LSB=0 and DELAYCOUNT_LSB=16;
  - the count width 16.
- One natural sub-module: capture_ring_ptr.
  - Contents: wrPtr/rdPtr registers with increment, decrement and load.
  - Ports: clock, reset, inc, dec, load.
- The FSM stays in capture_controller.

Test Plan:
- Reset mid-readback (reset=0 during SENDWAIT) -> all outputs 0 immediately, state IDLE; the next arm starts a clean SAMPLE.
- wrSize data=0x0001_0000, arm, 10 samples, run, then 8 samples 0xA0..0xA7, busy=0 -> 8 post-trigger writes, then IDLE; send pulses 4 times with txData 0xA7, 0xA6, 0xA5, 0xA4.
- run and inputReady in the same cycle with value 0x55 -> 0x55 written and not counted; exactly 4*(delayCount+1) further writes follow.
- ADDR_WIDTH=4, 20 samples before run -> wrPtr wraps 15->0; readback addresses decrement through 0->15 correctly.
- busy held high 5 cycles after each send -> no memRead until busy=0; send never pulses twice for one word.
- arm asserted during READ -> send stays 0, state SAMPLE; arm and run together in SAMPLE -> stays SAMPLE with counter 0.

Source files
------------

// File: rtl/capture_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | capture_controller_pkg: shared states, command fields, count widths   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package capture_controller_pkg;

  localparam int COUNT_WIDTH    = 16;
  localparam int CNT_WIDTH      = COUNT_WIDTH + 2;
  localparam int READCOUNT_LSB  = 0;
  localparam int DELAYCOUNT_LSB = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SAMPLE   = 3'd1,
    S_DELAY    = 3'd2,
    S_READ     = 3'd3,
    S_READWAIT = 3'd4,
    S_SENDHOLD = 3'd5,
    S_SENDWAIT = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/capture_ring_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | capture_ring_ptr: ring-buffer write/read pointers                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module capture_ring_ptr #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  load,
  output logic [ADDR_WIDTH-1:0] wrPtr,
  output logic [ADDR_WIDTH-1:0] rdPtr
);

  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [ADDR_WIDTH-1:0] w_wrNext;

  assign w_wrNext = inc ? r_wrPtr + ADDR_WIDTH'(1) : r_wrPtr;

  // load captures the write pointer after any same-cycle increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      r_wrPtr <= w_wrNext;
      if (load) begin
        r_rdPtr <= w_wrNext;
      end else if (dec) begin
        r_rdPtr <= r_rdPtr - ADDR_WIDTH'(1);
      end
    end
  end

  assign wrPtr = r_wrPtr;
  assign rdPtr = r_rdPtr;

endmodule
`default_nettype wire

// File: rtl/capture_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | capture_controller: ring-buffer capture and newest-first readback     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module capture_controller
  import capture_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataInput,
  input  logic                  inputReady,
  input  logic                  run,
  input  logic                  arm,
  input  logic                  wrSize,
  input  logic [31:0]           data,
  input  logic                  busy,
  output logic                  send,
  output logic [DATA_WIDTH-1:0] txData,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWData,
  output logic                  memWrite,
  output logic                  memRead,
  input  logic [DATA_WIDTH-1:0] memRData,
  output logic                  capturing
);

  state_t                 r_state,    w_state_next;
  logic [CNT_WIDTH-1:0]   r_counter,  w_counter_next;
  logic [COUNT_WIDTH-1:0] r_readCount;
  logic [COUNT_WIDTH-1:0] r_delayCount;
  logic                   r_send,     w_send_next;
  logic [DATA_WIDTH-1:0]  r_txData,   w_txData_next;
  logic [ADDR_WIDTH-1:0]  r_memAddr,  w_memAddr_next;
  logic [DATA_WIDTH-1:0]  r_memWData, w_memWData_next;
  logic                   r_memWrite, w_memWrite_next;
  logic                   r_memRead,  w_memRead_next;
  logic                   w_inc, w_dec, w_load;
  logic [ADDR_WIDTH-1:0]  w_wrPtr, w_rdPtr;

  capture_ring_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (w_inc),
    .dec   (w_dec),
    .load  (w_load),
    .wrPtr (w_wrPtr),
    .rdPtr (w_rdPtr)
  );

  always_comb begin
    w_state_next    = r_state;
    w_counter_next  = r_counter;
    w_send_next     = 1'b0;
    w_txData_next   = r_txData;
    w_memAddr_next  = r_memAddr;
    w_memWData_next = r_memWData;
    w_memWrite_next = 1'b0;
    w_memRead_next  = 1'b0;
    w_inc           = 1'b0;
    w_dec           = 1'b0;
    w_load          = 1'b0;

    if (arm) begin
      w_state_next   = S_SAMPLE;
      w_counter_next = '0;
    end else begin
      if ((r_state == S_SAMPLE || r_state == S_DELAY) && inputReady) begin
        w_memWrite_next = 1'b1;
        w_memAddr_next  = w_wrPtr;
        w_memWData_next = dataInput;
        w_inc           = 1'b1;
      end
      case (r_state)
        S_IDLE: ;
        S_SAMPLE: begin
          if (run) begin
            w_state_next   = S_DELAY;
            w_counter_next = '0;
          end
        end
        S_DELAY: begin
          if (inputReady) begin
            if (r_counter == {r_delayCount, 2'b11}) begin
              w_state_next   = S_READ;
              w_counter_next = '0;
              w_load         = 1'b1;
            end else begin
              w_counter_next = r_counter + CNT_WIDTH'(1);
            end
          end
        end
        S_READ: begin
          if (!busy) begin
            w_memRead_next = 1'b1;
            w_memAddr_next = w_rdPtr - ADDR_WIDTH'(1);
            w_dec          = 1'b1;
            w_state_next   = S_READWAIT;
          end
        end
        // memRData is valid the cycle after the read strobe
        S_READWAIT: begin
          if (!r_memRead) begin
            w_txData_next = memRData;
            w_send_next   = 1'b1;
            w_state_next  = S_SENDHOLD;
          end
        end
        S_SENDHOLD: w_state_next = S_SENDWAIT;
        S_SENDWAIT: begin
          if (!busy) begin
            if (r_counter == {r_readCount, 2'b11}) begin
              w_state_next = S_IDLE;
            end else begin
              w_counter_next = r_counter + CNT_WIDTH'(1);
              w_state_next   = S_READ;
            end
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_counter    <= '0;
      r_readCount  <= '0;
      r_delayCount <= '0;
      r_send       <= 1'b0;
      r_txData     <= '0;
      r_memAddr    <= '0;
      r_memWData   <= '0;
      r_memWrite   <= 1'b0;
      r_memRead    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_counter  <= w_counter_next;
      r_send     <= w_send_next;
      r_txData   <= w_txData_next;
      r_memAddr  <= w_memAddr_next;
      r_memWData <= w_memWData_next;
      r_memWrite <= w_memWrite_next;
      r_memRead  <= w_memRead_next;
      if (wrSize) begin
        r_readCount  <= data[READCOUNT_LSB +: COUNT_WIDTH];
        r_delayCount <= data[DELAYCOUNT_LSB +: COUNT_WIDTH];
      end
    end
  end

  assign send      = r_send;
  assign txData    = r_txData;
  assign memAddr   = r_memAddr;
  assign memWData  = r_memWData;
  assign memWrite  = r_memWrite;
  assign memRead   = r_memRead;
  assign capturing = (r_state == S_SAMPLE) || (r_state == S_DELAY);

endmodule
`default_nettype wire

// File: tb/tb_capture_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_capture_controller: directed bench with a 16-word ring memory      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_capture_controller;

  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   dataInput = '0;
  logic          inputReady = 1'b0;
  logic          run = 1'b0;
  logic          arm = 1'b0;
  logic          wrSize = 1'b0;
  logic [31:0]   data = '0;
  logic          busy;
  logic          send;
  logic [31:0]   txData;
  logic [AW-1:0] memAddr;
  logic [31:0]   memWData;
  logic          memWrite;
  logic          memRead;
  logic [31:0]   memRData;
  logic          capturing;

  logic          busy_mon = 1'b0;
  logic          force_busy = 1'b0;
  assign busy = busy_mon | force_busy;

  capture_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .dataInput(dataInput), .inputReady(inputReady),
    .run(run), .arm(arm), .wrSize(wrSize), .data(data), .busy(busy), .send(send),
    .txData(txData), .memAddr(memAddr), .memWData(memWData), .memWrite(memWrite),
    .memRead(memRead), .memRData(memRData), .capturing(capturing)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [16];
  always @(posedge clock) begin
    if (memWrite) mem[memAddr] <= memWData;
    if (memRead)  memRData <= mem[memAddr];
  end

  // Monitor and transmitter model: busy stays high busy_hold cycles per send
  int          wr_cnt = 0, rd_cnt = 0, send_cnt = 0, viol = 0;
  int          busy_hold = 0, bcnt = 0;
  logic        b_edge;
  logic [31:0] tx_q[$];
  always @(posedge clock) begin
    b_edge = busy;
    #1;
    if (memWrite) wr_cnt++;
    if (memRead) begin
      rd_cnt++;
      if (b_edge || memWrite) viol++;
    end
    if (send) begin
      send_cnt++;
      tx_q.push_back(txData);
      if (busy_hold > 0) begin
        busy_mon = 1'b1;
        bcnt = busy_hold;
      end
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) busy_mon = 1'b0;
    end
  end

  int n_err = 0, n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic cfg(input logic [15:0] d, input logic [15:0] r);
    data = {d, r}; wrSize = 1'b1; tick(); wrSize = 1'b0; tick();
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0; tick();
  endtask

  task automatic sample(input logic [31:0] v);
    dataInput = v; inputReady = 1'b1; tick(); inputReady = 1'b0; tick();
  endtask

  task automatic do_run(input bit with_sample);
    run = 1'b1;
    if (with_sample) begin
      dataInput = 32'h55; inputReady = 1'b1;
    end
    tick(); run = 1'b0; inputReady = 1'b0; tick();
  endtask

  task automatic feed_post(input logic [31:0] base);
    for (int i = 0; i < 64; i++) begin
      if (!capturing) break;
      sample(base + 32'(i));
    end
  endtask

  task automatic wait_sends(input int base, input int n);
    for (int k = 0; k < 3000; k++) begin
      if (send_cnt - base >= n) break;
      tick();
    end
    repeat (30) tick();
  endtask

  function automatic logic [31:0] txat(input int idx);
    return (idx < tx_q.size()) ? tx_q[idx] : 32'hDEAD_DEAD;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_send"}, 32'(send), 32'h0);
    chk({tag, "_txData"}, txData, 32'h0);
    chk({tag, "_memAddr"}, 32'(memAddr), 32'h0);
    chk({tag, "_memWData"}, memWData, 32'h0);
    chk({tag, "_memWrite"}, 32'(memWrite), 32'h0);
    chk({tag, "_memRead"}, 32'(memRead), 32'h0);
    chk({tag, "_capturing"}, 32'(capturing), 32'h0);
  endtask

  typedef struct {
    logic [15:0] dcnt;
    logic [15:0] rcnt;
    int          npre;
    int          hold;
    bit          same;
    int          exp_wr;
    int          exp_tx;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, s0, r0;
    vecs[0] = '{16'd1, 16'd0, 10, 0, 1'b0, 8, 4, 32'hA7, 32'hA4};
    vecs[1] = '{16'd0, 16'd1, 3, 0, 1'b1, 5, 8, 32'hA3, 32'h10};
    vecs[2] = '{16'd0, 16'd3, 20, 0, 1'b0, 4, 16, 32'hA3, 32'h18};
    vecs[3] = '{16'd0, 16'd0, 2, 5, 1'b0, 4, 4, 32'hA3, 32'hA0};

    #1 reset = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    reset = 1'b1;
    tick();

    foreach (vecs[n]) begin
      busy_hold = vecs[n].hold;
      cfg(vecs[n].dcnt, vecs[n].rcnt);
      do_arm();
      for (int i = 0; i < vecs[n].npre; i++) sample(32'h10 + 32'(i));
      wr0 = wr_cnt;
      s0  = send_cnt;
      do_run(vecs[n].same);
      feed_post(32'hA0);
      wait_sends(s0, vecs[n].exp_tx);
      chk($sformatf("v%0d_writes_after_run", n), 32'(wr_cnt - wr0), 32'(vecs[n].exp_wr));
      chk($sformatf("v%0d_send_count", n), 32'(send_cnt - s0), 32'(vecs[n].exp_tx));
      chk($sformatf("v%0d_first_tx", n), txat(s0), vecs[n].first);
      chk($sformatf("v%0d_last_tx", n), txat(s0 + vecs[n].exp_tx - 1), vecs[n].last);
    end

    // Reset while waiting on a busy transmitter mid-readback
    busy_hold = 5;
    cfg(16'd0, 16'd3);
    do_arm();
    sample(32'h20); sample(32'h21);
    s0 = send_cnt;
    do_run(1'b0);
    feed_post(32'hA0);
    for (int k = 0; k < 200 && send_cnt == s0; k++) tick();
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    tick();
    reset = 1'b1;
    busy_hold = 0;
    repeat (8) tick();
    do_arm();
    chk("rearm_capturing", 32'(capturing), 32'h1);
    s0 = send_cnt;
    do_run(1'b0);
    feed_post(32'hB0);
    wait_sends(s0, 4);
    chk("rearm_send_count", 32'(send_cnt - s0), 32'd4);
    chk("rearm_first_tx", txat(s0), 32'hB3);

    // Abort a stalled readback with arm, then arm+run together in SAMPLE
    cfg(16'd0, 16'd0);
    do_arm();
    sample(32'h30); sample(32'h31);
    do_run(1'b0);
    force_busy = 1'b1;
    r0 = rd_cnt;
    s0 = send_cnt;
    feed_post(32'hC0);
    repeat (5) tick();
    chk("stalled_read_no_memread", 32'(rd_cnt - r0), 32'h0);
    do_arm();
    force_busy = 1'b0;
    repeat (10) tick();
    chk("abort_no_send", 32'(send_cnt - s0), 32'h0);
    chk("abort_capturing", 32'(capturing), 32'h1);
    arm = 1'b1; run = 1'b1; tick(); arm = 1'b0; run = 1'b0; tick();
    for (int i = 0; i < 6; i++) sample(32'h40 + 32'(i));
    chk("arm_run_stays_sample", 32'(capturing), 32'h1);
    s0 = send_cnt;
    do_run(1'b0);
    feed_post(32'hD0);
    wait_sends(s0, 4);
    chk("after_abort_send_count", 32'(send_cnt - s0), 32'd4);
    chk("after_abort_first_tx", txat(s0), 32'hD3);

    chk("strobe_rules", 32'(viol), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
